// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Owns the fetch PC, issues in-order reads to instruction memory, buffers
// returned {pc, word} pairs in a small prefetch FIFO and hands them to decode
// over valid/ready. A taken branch redirects fetch, flushes the FIFO and
// arranges for in-flight responses to be dropped.
// Optional feature: define FETCH_BYPASS_EN to forward a returning word
// straight to decode when the FIFO is empty (saves one cycle of latency).
module fetch_unit #(
  parameter int unsigned          ADDR_W   = 11,
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_address,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_radrs,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_rvalid,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // In-flight reads are bounded by memory latency (one issue per cycle), so a
  // few bits of headroom over the FIFO pointer are plenty.
  localparam int unsigned CNT_W = PTR_W + 4;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic              rsp_accept;
  logic              rsp_keep;
  logic              fifo_empty;
  logic              bypass;
  logic              push;
  logic              pop;
  logic              issue;
  logic [CNT_W:0]    in_use;

  // Response qualification, credit check and FIFO handshake decode.
  always_comb begin
    // A response with nothing outstanding is spurious and ignored entirely.
    rsp_accept = imem_rvalid && (outstanding_q != '0);
    rsp_keep   = rsp_accept && (discard_q == '0);
    fifo_empty = (count_q == '0);
    // Slots already claimed: buffered words plus live (non-discarded) reads.
    in_use     = (CNT_W+1)'(count_q) + (CNT_W+1)'(outstanding_q) - (CNT_W+1)'(discard_q);
    issue      = !reset && !branch_valid && (in_use < (CNT_W+1)'(DEPTH));
`ifdef FETCH_BYPASS_EN
    bypass     = fifo_empty && rsp_keep && !branch_valid;
`else
    bypass     = 1'b0;
`endif
    pop        = !fifo_empty && instr_ready;
    // A bypassed word that decode takes immediately never enters the FIFO.
    push       = rsp_keep && !branch_valid && !(bypass && instr_ready);
  end

  // Outputs to memory and decode.
  always_comb begin
    imem_rd     = issue;
    imem_radrs  = fetch_pc_q;
    instr_valid = !fifo_empty || bypass;
    instr_out   = '0;
    instr_pc    = '0;
    if (bypass) begin
      instr_out = imem_rdata;
      instr_pc  = rsp_pc_q;
    end else if (!fifo_empty) begin
      instr_out = data_mem[rd_ptr_q];
      instr_pc  = pc_mem[rd_ptr_q];
    end
  end

  // Next-state for PCs, counters and FIFO pointers; branch overrides all.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(rsp_accept);
    discard_d     = discard_q;
    count_d       = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    rd_ptr_d      = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

    if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end
    if (rsp_keep) begin
      rsp_pc_d = rsp_pc_q + ADDR_W'(1);
    end
    if (rsp_accept && (discard_q != '0)) begin
      discard_d = discard_q - CNT_W'(1);
    end

    if (branch_valid) begin
      fetch_pc_d = branch_address;
      rsp_pc_d   = branch_address;
      // Every read still in flight is stale; one returning now is dropped here.
      discard_d  = outstanding_q - CNT_W'(rsp_accept);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // FIFO storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]   <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven stream vectors plus
// directed sequences for backpressure, branches, wrap and async reset.
module tb_fetch_unit;

  localparam int AW = 11;
  localparam int DW = 32;
`ifdef FETCH_BYPASS_EN
  localparam int X = 0;  // extra output latency over the memory response
`else
  localparam int X = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          branch_valid = 1'b0;
  logic [AW-1:0] branch_address = '0;
  logic          imem_rd;
  logic [AW-1:0] imem_radrs;
  logic [DW-1:0] imem_rdata;
  logic          imem_rvalid;
  logic [DW-1:0] instr_out;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b1;

  int n_chk = 0;
  int n_err = 0;
  int lat = 1;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .branch_valid   (branch_valid),
    .branch_address (branch_address),
    .imem_rd        (imem_rd),
    .imem_radrs     (imem_radrs),
    .imem_rdata     (imem_rdata),
    .imem_rvalid    (imem_rvalid),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | {{(DW-AW){1'b0}}, a};
  endfunction

  // Fixed-latency memory model, reset together with the DUT.
  logic          pipe_v [8];
  logic [AW-1:0] pipe_a [8];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_a[i] <= '0;
      end
    end else begin
      for (int i = 7; i > 0; i--) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
      pipe_v[0] <= imem_rd;
      pipe_a[0] <= imem_radrs;
    end
  end
  assign imem_rvalid = pipe_v[lat-1];
  assign imem_rdata  = mem_word(pipe_a[lat-1]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next cycle: drive inputs after the falling edge, settle.
  task automatic step(input logic rdy, input logic bv, input logic [AW-1:0] ba);
    @(negedge clk);
    instr_ready    = rdy;
    branch_valid   = bv;
    branch_address = ba;
    #1;
  endtask

  // Hold reset, then release at a falling edge; returns inside cycle 0.
  task automatic do_reset(input int l);
    reset        = 1'b1;
    branch_valid = 1'b0;
    instr_ready  = 1'b1;
    lat          = l;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Step with ready=1 until instr_valid; n = cycles stepped, 0 on timeout.
  task automatic wait_valid(input int budget, output int n, output logic [AW-1:0] pc,
                            output logic [DW-1:0] d);
    n  = 0;
    pc = '0;
    d  = '0;
    for (int i = 1; i <= budget; i++) begin
      step(1'b1, 1'b0, '0);
      if (instr_valid) begin
        n  = i;
        pc = instr_pc;
        d  = instr_out;
        break;
      end
    end
  endtask

  typedef struct {
    logic          ready;
    logic          exp_rd;
    logic [AW-1:0] exp_radrs;
    logic          exp_valid;
    logic [AW-1:0] exp_pc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic rd, input int ra, input logic v, input int pc);
    vec_t e;
    e.ready     = r;
    e.exp_rd    = rd;
    e.exp_radrs = AW'(ra);
    e.exp_valid = v;
    e.exp_pc    = AW'(pc);
    tbl.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    int            issued;
    logic [AW-1:0] pc;
    logic [DW-1:0] d;

    // Latency-1 stream with a two-cycle decode stall (ready, rd, radrs, valid, pc).
`ifdef FETCH_BYPASS_EN
    add(1, 1, 0, 0, 0);  add(1, 1, 1, 1, 0);  add(1, 1, 2, 1, 1);  add(1, 1, 3, 1, 2);
    add(1, 1, 4, 1, 3);  add(0, 1, 5, 1, 4);  add(0, 1, 6, 1, 4);  add(1, 1, 7, 1, 4);
    add(1, 1, 8, 1, 5);  add(1, 1, 9, 1, 6);  add(1, 1, 10, 1, 7); add(1, 1, 11, 1, 8);
`else
    add(1, 1, 0, 0, 0);  add(1, 1, 1, 0, 0);  add(1, 1, 2, 1, 0);  add(1, 1, 3, 1, 1);
    add(1, 1, 4, 1, 2);  add(0, 1, 5, 1, 3);  add(0, 1, 6, 1, 3);  add(1, 0, 7, 1, 3);
    add(1, 1, 7, 1, 4);  add(1, 1, 8, 1, 5);  add(1, 1, 9, 1, 6);  add(1, 1, 10, 1, 7);
`endif

    // Reset state while reset is held.
    #3;
    chk("rst_imem_rd", imem_rd, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr_out", instr_out, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_imem_radrs", imem_radrs, 0);

    // Table-driven stream.
    do_reset(1);
    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) step(tbl[i].ready, 1'b0, '0);
      else begin
        instr_ready = tbl[i].ready;
        #1;
      end
      chk($sformatf("tbl%0d_rd", i), imem_rd, tbl[i].exp_rd);
      if (tbl[i].exp_rd) chk($sformatf("tbl%0d_radrs", i), imem_radrs, tbl[i].exp_radrs);
      chk($sformatf("tbl%0d_valid", i), instr_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].exp_pc);
        chk($sformatf("tbl%0d_out", i), instr_out, mem_word(tbl[i].exp_pc));
      end
    end

    // Backpressure: ready low for 10 cycles, exactly DEPTH reads, head stable.
    do_reset(1);
    instr_ready = 1'b0;
    #1;
    issued = 0;
    for (int c = 0; c < 10; c++) begin
      if (c != 0) step(1'b0, 1'b0, '0);
      issued += int'(imem_rd);
      if (instr_valid) begin
        chk("bp_hold_pc", instr_pc, 0);
        chk("bp_hold_out", instr_out, mem_word('0));
      end
    end
    chk("bp_issued", issued, 4);
    for (int j = 0; j < 6; j++) begin
      step(1'b1, 1'b0, '0);
      if (j == 0) chk("bp_full_no_rd", imem_rd, 0);
      if (j == 1) chk("bp_rd_resume", imem_rd, 1);
      chk("bp_rel_valid", instr_valid, 1);
      chk("bp_rel_pc", instr_pc, AW'(j));
      chk("bp_rel_out", instr_out, mem_word(AW'(j)));
    end

    // Branch with three reads in flight (latency 3).
    do_reset(3);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 11'h100);
    chk("br_no_issue", imem_rd, 0);
    chk("br_cycle_valid", instr_valid, 0);
    step(1'b1, 1'b0, '0);
    chk("br_next_valid", instr_valid, 0);
    chk("br_next_rd", imem_rd, 1);
    chk("br_next_radrs", imem_radrs, 11'h100);
    wait_valid(12, n, pc, d);
    chk("br_first_lat", n, 3 + X);
    chk("br_first_pc", pc, 11'h100);
    chk("br_first_out", d, mem_word(11'h100));
    step(1'b1, 1'b0, '0);
    chk("br_second_valid", instr_valid, 1);
    chk("br_second_pc", instr_pc, 11'h101);

    // Branch colliding with a pop and a returning word, then wrap at 0x7FF.
    do_reset(2);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk("col_pre_valid", instr_valid, 1);
    chk("col_pre_pc", instr_pc, 0);
    step(1'b1, 1'b1, 11'h7FE);
    chk("col_pop_valid", instr_valid, 1);
    chk("col_pop_pc", instr_pc, 0);
    chk("col_pop_rvalid", imem_rvalid, 1);
    step(1'b1, 1'b0, '0);
    chk("col_empty", instr_valid, 0);
    chk("col_radrs", imem_radrs, 11'h7FE);
    chk("col_rd", imem_rd, 1);
    wait_valid(12, n, pc, d);
    chk("wrap_lat", n, 2 + X);
    chk("wrap_pc0", pc, 11'h7FE);
    chk("wrap_out0", d, mem_word(11'h7FE));
    step(1'b1, 1'b0, '0);
    chk("wrap_pc1", instr_pc, 11'h7FF);
    chk("wrap_out1", instr_out, mem_word(11'h7FF));
    step(1'b1, 1'b0, '0);
    chk("wrap_valid2", instr_valid, 1);
    chk("wrap_pc2", instr_pc, 11'h000);
    chk("wrap_out2", instr_out, mem_word(11'h000));

    // Asynchronous reset between edges with two words buffered.
    do_reset(1);
    instr_ready = 1'b0;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk("ar_pre_valid", instr_valid, 1);
    chk("ar_pre_pc", instr_pc, 0);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", instr_valid, 0);
    chk("ar_rd", imem_rd, 0);
    chk("ar_out", instr_out, 0);
    chk("ar_pc", instr_pc, 0);
    chk("ar_radrs", imem_radrs, 0);
    do_reset(1);
    chk("ar_restart_rd", imem_rd, 1);
    chk("ar_restart_radrs", imem_radrs, 0);
    wait_valid(8, n, pc, d);
    chk("ar_restart_lat", n, 1 + X);
    chk("ar_restart_pc", pc, 0);
    chk("ar_restart_out", d, mem_word('0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
